memory: RTL and testbench
=========================

// Module: memory
// PURPOSE
// - Single-port synchronous SRAM model: 128 words x 16 bits, one clock, active-low chip/write enables.
// - Used as the on-chip scratch store and as the behavioural stand-in for the SRAM macro in the datapath.
// - Read data is registered, so read latency is one cycle. Contents are written one word per cycle.
// PARAMETERS
// - DATA_W   16   word width in bits
// - ADDR_W   7    address width; depth = 2**ADDR_W = 128 words
// PORTS (module port order: data_out, clk, cen, wen, addr, data_in, rst_n)
// - clk       in   1       single clock; all state changes on the rising edge
// - rst_n     in   1       reset, asynchronous, active-low
// - cen       in   1       chip enable, active-low; 0 = access performed this edge
// - wen       in   1       write enable, active-low; 0 = write, 1 = read (only when cen=0)
// - addr      in   ADDR_W  word address, 0..127
// - data_in   in   DATA_W  write data
// - data_out  out  DATA_W  registered read data
// BEHAVIOUR
// - Reset: rst_n=0 forces data_out=16'h0000 immediately, with no clock needed. Array contents are not reset.
// - Array contents are undefined (X in simulation) until written. Reset never alters stored words.
// - All operations are sampled at posedge clk. addr, data_in, cen and wen must be stable around that edge.
// - cen=0, wen=0 (write): mem[addr] <= data_in. data_out holds its value unless MEMORY_WRITE_THROUGH_EN is defined.
// - cen=0, wen=1 (read): data_out <= mem[addr]. The value is valid after the same edge (1-cycle latency).
// - cen=1 (idle): no array access; data_out holds its value; wen, addr and data_in are ignored.
// - Read and write are mutually exclusive per cycle (single port); there is no read/write collision case.
// - Back-to-back accesses to any addresses are allowed every cycle; there are no wait states and no busy output.
// - A write followed next cycle by a read of the same address returns the newly written data.
// - Address is full-range: every 7-bit value is a valid word, so there is no out-of-range case.
// - Address wrap (127 -> 0) is the caller's concern; the memory is not address-incrementing.
// - If rst_n asserts mid-operation, the access on that edge is abandoned and data_out=0.
// - Only the write committed on a prior edge persists.
// - X or Z on cen or wen (simulation only): no write occurs; data_out is driven to X to flag misuse.
// CONFIGURATION
// - MEMORY_WRITE_THROUGH_EN defined: on a write cycle (cen=0, wen=0), data_out <= data_in on the same edge.
// - MEMORY_WRITE_THROUGH_EN undefined (default): data_out is unchanged by write cycles and is updated only by reads.
// TESTING
// - Reset: rst_n=0 at t=0 with clk idle -> data_out=16'h0000 before any clk edge.
// - Fill: cen=0, wen=0, write addr n with data n for n=0..126, one per cycle (100 ns half-period).
//   -> no data_out change (default build).
// - Readback: cen=0, wen=1, addr 0..126 -> data_out equals addr on the cycle after each address is presented.
// - Idle: after reading addr 5 (data_out=5), set cen=1 and change addr/wen/data_in -> data_out stays 5.
//   -> No array word changes (confirm by re-reading addr 10 = 10).
// - Write-then-read: write 16'hBEEF to addr 127, read addr 127 next cycle -> data_out=16'hBEEF.
//   -> With MEMORY_WRITE_THROUGH_EN, data_out=16'hBEEF already after the write edge.
// - Reset mid-run: assert rst_n=0 during a read of addr 3 -> data_out=0 at once.
//   -> After release, reading addr 3 returns 3 (contents retained).

Source files
------------

// File: rtl/memory.sv
// Single-port 128x16 synchronous SRAM model with a registered, 1-cycle-latency read port.
// Optional define MEMORY_WRITE_THROUGH_EN: a write also loads data_in into data_out.
module memory #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 7
) (
   output logic [DATA_W-1:0] data_out,
   input  logic              clk,
   input  logic              cen,
   input  logic              wen,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   input  logic              rst_n
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              wr_en, rd_en, idle;

   // Decoded with == so an X/Z control never enables a write or a read.
   assign idle  = (cen == 1'b1);
   assign wr_en = (cen == 1'b0) && (wen == 1'b0);
   assign rd_en = (cen == 1'b0) && (wen == 1'b1);

   always_comb begin
      data_out_d = data_out_q;
      if (idle) begin
         data_out_d = data_out_q;
      end else if (rd_en) begin
         data_out_d = mem_q[addr];
      end else if (wr_en) begin
`ifdef MEMORY_WRITE_THROUGH_EN
         data_out_d = data_in;
`else
         data_out_d = data_out_q;
`endif
      end else begin
         data_out_d = 'x;
      end
   end

   // Array has no reset; a write on an edge where reset is asserted is dropped.
   always_ff @(posedge clk) begin
      if (rst_n && wr_en) begin
         mem_q[addr] <= data_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out_q <= '0;
      end else begin
         data_out_q <= data_out_d;
      end
   end

   assign data_out = data_out_q;

endmodule

// File: tb/tb_memory.sv
// Directed bench for memory: fill, readback, idle hold, write-then-read and mid-run reset.
module tb_memory;

   logic        clk = 1'b0;
   logic        rst_n, cen, wen;
   logic [6:0]  addr;
   logic [15:0] data_in, data_out;
   bit          run = 1'b0;
   int          checks = 0;
   int          failures = 0;
   logic [15:0] exp_q [$];

`ifdef MEMORY_WRITE_THROUGH_EN
   localparam bit WT = 1'b1;
`else
   localparam bit WT = 1'b0;
`endif

   memory dut (
      .data_out (data_out),
      .clk      (clk),
      .cen      (cen),
      .wen      (wen),
      .addr     (addr),
      .data_in  (data_in),
      .rst_n    (rst_n)
   );

   always #100 if (run) clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one access, push its expected data_out, compare on the following negedge.
   task automatic cyc(input logic c, input logic w, input logic [6:0] a,
                      input logic [15:0] d, input logic [15:0] exp, input string tag);
      cen = c; wen = w; addr = a; data_in = d;
      exp_q.push_back(exp);
      @(posedge clk);
      @(negedge clk);
      check(tag, data_out, exp_q.pop_front());
   endtask

   initial begin
      rst_n = 1'b0; cen = 1'b1; wen = 1'b1; addr = '0; data_in = '0;
      #50;
      check("reset_no_clk", data_out, 16'h0000);
      rst_n = 1'b1;
      #10 run = 1'b1;

      for (int n = 0; n < 127; n++)
         cyc(1'b0, 1'b0, 7'(n), 16'(n), WT ? 16'(n) : 16'h0000, "fill");

      for (int n = 0; n < 127; n++)
         cyc(1'b0, 1'b1, 7'(n), 16'hFFFF, 16'(n), "readback");

      cyc(1'b0, 1'b1, 7'd5, 16'h0000, 16'd5, "idle_pre_read5");
      cyc(1'b1, 1'b0, 7'd10, 16'hDEAD, 16'd5, "idle_wen0");
      cyc(1'b1, 1'b1, 7'd77, 16'h1111, 16'd5, "idle_wen1");
      cyc(1'b1, 1'b0, 7'd0, 16'hAAAA, 16'd5, "idle_addr0");
      cyc(1'b0, 1'b1, 7'd10, 16'h0000, 16'd10, "idle_no_write_10");
      cyc(1'b0, 1'b1, 7'd0, 16'h0000, 16'd0, "idle_no_write_0");

      cyc(1'b0, 1'b0, 7'd127, 16'hBEEF, WT ? 16'hBEEF : 16'd0, "wr127");
      cyc(1'b0, 1'b1, 7'd127, 16'h0000, 16'hBEEF, "rd127");
      cyc(1'b0, 1'b1, 7'd126, 16'h0000, 16'd126, "rd126");

      cyc(1'b0, 1'b1, 7'd9, 16'h0000, 16'd9, "pre_reset_read9");
      cen = 1'b0; wen = 1'b1; addr = 7'd3;
      #50 rst_n = 1'b0;
      #1 check("reset_async", data_out, 16'h0000);
      @(posedge clk);
      @(negedge clk);
      check("reset_hold_edge", data_out, 16'h0000);
      cen = 1'b0; wen = 1'b0; addr = 7'd4; data_in = 16'h1234;
      @(posedge clk);
      @(negedge clk);
      check("reset_write_dropped_out", data_out, 16'h0000);
      rst_n = 1'b1;
      cyc(1'b0, 1'b1, 7'd3, 16'h0000, 16'd3, "post_reset_rd3");
      cyc(1'b0, 1'b1, 7'd4, 16'h0000, 16'd4, "post_reset_rd4");
      cyc(1'b1, 1'b1, 7'd4, 16'h0000, 16'd4, "post_reset_idle");

      run = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
